// File: rtl/credit_retry_requester_pkg.sv
// Shared types for the credit/retry requester: held transaction, park slot and output FSM states.
package credit_req_pkg;

   localparam int ID_W_DEF = 3;
   localparam int PL_W_DEF = 5;

   typedef struct packed {
      logic [ID_W_DEF-1:0] id;
      logic [PL_W_DEF-1:0] payload;
   } txn_t;

   typedef enum logic [1:0] {
      O_IDLE,
      O_NEW,
      O_CRED
   } out_state_e;

   typedef struct packed {
      logic                valid;
      logic                granted;
      logic [PL_W_DEF-1:0] payload;
   } park_slot_t;

endpackage

// File: rtl/credit_retry_requester_if.sv
// Source, receiver and credit-grant signals of the requester; master is the requester side.
interface credit_retry_requester_if #(
   parameter int ID_W = 3,
   parameter int PL_W = 5
);
   logic            src_valid_i;
   logic [ID_W-1:0] src_id_i;
   logic [PL_W-1:0] src_payload_i;
   logic            src_ready_o;
   logic            out_valid_o;
   logic [ID_W-1:0] out_id_o;
   logic [PL_W-1:0] out_payload_o;
   logic            out_credit_o;
   logic            out_ready_i;
   logic            out_retry_i;
   logic            credit_gnt_i;
   logic [ID_W-1:0] credit_id_i;
   logic [ID_W:0]   parked_cnt_o;
   logic            spurious_credit_o;

   modport master (
      input  src_valid_i, src_id_i, src_payload_i, out_ready_i, out_retry_i,
             credit_gnt_i, credit_id_i,
      output src_ready_o, out_valid_o, out_id_o, out_payload_o, out_credit_o,
             parked_cnt_o, spurious_credit_o
   );

   modport slave (
      output src_valid_i, src_id_i, src_payload_i, out_ready_i, out_retry_i,
             credit_gnt_i, credit_id_i,
      input  src_ready_o, out_valid_o, out_id_o, out_payload_o, out_credit_o,
             parked_cnt_o, spurious_credit_o
   );
endinterface

// File: rtl/credit_retry_requester_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping; N is 2**IDX_W.
module rr_arbiter #(
   parameter int IDX_W = 3,
   parameter int N     = 1 << IDX_W
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);
   logic             found;
   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      // cand wraps naturally because N is a power of two
      for (int k = 0; k < N; k++) begin
         cand = ptr + IDX_W'(k);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end
endmodule

// File: rtl/credit_retry_requester.sv
// Feeds the credit receiver; retried transactions are parked per ID and resent credited once granted.
module credit_retry_requester
   import credit_req_pkg::*;
#(
   parameter int ID_W = ID_W_DEF,
   parameter int PL_W = PL_W_DEF
) (
   input logic                      clk,
   input logic                      reset,
   credit_retry_requester_if.master bus
);
   localparam int N = 1 << ID_W;

   out_state_e      state_q, state_d;
   txn_t            hold_q;
   park_slot_t      slot_q [N];
   logic [ID_W-1:0] rr_ptr_q;
   logic [ID_W:0]   cnt_q;
   logic            spur_q;

   logic            out_valid, accept, retry, free, pend, gnt_ok;
   logic            load_park, load_src;
   logic [N-1:0]    ready_vec, arb_gnt;
   logic [ID_W-1:0] arb_idx;

   always_comb begin
      ready_vec = '0;
      for (int i = 0; i < N; i++) ready_vec[i] = slot_q[i].valid & slot_q[i].granted;
   end

   rr_arbiter #(.IDX_W(ID_W), .N(N)) u_arb (
      .req (ready_vec),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   assign out_valid = (state_q != O_IDLE);
   assign accept    = out_valid & bus.out_ready_i;
   assign retry     = out_valid & bus.out_retry_i & ~bus.out_ready_i;
   assign free      = ~out_valid | accept | retry;
   assign pend      = |ready_vec;

   // Blocking a parked ID at the source keeps per-ID ordering intact
   assign bus.src_ready_o = free & ~pend & ~slot_q[bus.src_id_i].valid;

   // A retry landing on the granted ID in the same cycle makes the grant stale
   assign gnt_ok = slot_q[bus.credit_id_i].valid & ~slot_q[bus.credit_id_i].granted &
                   ~(retry & (hold_q.id == bus.credit_id_i));

   assign bus.out_valid_o       = out_valid;
   assign bus.out_id_o          = hold_q.id;
   assign bus.out_payload_o     = hold_q.payload;
   assign bus.out_credit_o      = (state_q == O_CRED);
   assign bus.parked_cnt_o      = cnt_q;
   assign bus.spurious_credit_o = spur_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= O_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      load_park = 1'b0;
      load_src  = 1'b0;
      if (free) begin
         if (pend) begin
            load_park = 1'b1;
            state_d   = O_CRED;
         end else if (bus.src_valid_i && bus.src_ready_o) begin
            load_src = 1'b1;
            state_d  = O_NEW;
         end else begin
            state_d = O_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q   <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         spur_q   <= 1'b0;
         for (int i = 0; i < N; i++) slot_q[i] <= '0;
      end else begin
         spur_q <= bus.credit_gnt_i & ~gnt_ok;
         if (load_park) begin
            hold_q   <= '{id: arb_idx, payload: slot_q[arb_idx].payload};
            rr_ptr_q <= arb_idx + 1'b1;
         end else if (load_src) begin
            hold_q <= '{id: bus.src_id_i, payload: bus.src_payload_i};
         end
         for (int i = 0; i < N; i++) begin
            if (retry && hold_q.id == ID_W'(i))
               slot_q[i] <= '{valid: 1'b1, granted: 1'b0, payload: hold_q.payload};
            else if (load_park && arb_gnt[i])
               slot_q[i] <= '0;
            else if (bus.credit_gnt_i && gnt_ok && bus.credit_id_i == ID_W'(i))
               slot_q[i].granted <= 1'b1;
         end
         case ({retry, load_park})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: tb/tb_credit_retry_requester.sv
// Directed bench for credit_retry_requester with a per-cycle behavioural model and literal spot checks.
module tb_credit_retry_requester;
   localparam int N = 8;

   logic clk = 1'b0;
   logic reset;

   credit_retry_requester_if #(.ID_W(3), .PL_W(5)) bus ();
   credit_retry_requester #(.ID_W(3), .PL_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int dut_log[$];

   // model: held transaction plus per-ID park table
   bit m_hv, m_hcr, m_sp;
   int m_hid, m_hpl, m_ptr;
   bit pv[N];
   bit pg[N];
   int ppl[N];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int enc(input int id, input int pl, input int cr);
      return id * 64 + pl * 2 + cr;
   endfunction

   task automatic mdl_reset();
      m_hv = 0; m_hcr = 0; m_sp = 0; m_hid = 0; m_hpl = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) begin pv[i] = 0; pg[i] = 0; ppl[i] = 0; end
   endtask

   function automatic int parked();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(pv[i]);
      return c;
   endfunction

   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         int j = (m_ptr + k) % N;
         if (pv[j] && pg[j]) return j;
      end
      return -1;
   endfunction

   function automatic bit mdl_free();
      return !m_hv || bus.out_ready_i || bus.out_retry_i;
   endfunction

   function automatic bit mdl_src_ready();
      return mdl_free() && pick() < 0 && !pv[bus.src_id_i];
   endfunction

   task automatic mdl_step();
      bit free   = mdl_free();
      bit rt     = m_hv && bus.out_retry_i && !bus.out_ready_i;
      bit sready = mdl_src_ready();
      int cid    = int'(bus.credit_id_i);
      int j      = pick();
      m_sp = bus.credit_gnt_i && !(pv[cid] && !pg[cid] && !(rt && m_hid == cid));
      if (bus.credit_gnt_i && !m_sp) pg[cid] = 1;
      if (rt) begin pv[m_hid] = 1; pg[m_hid] = 0; ppl[m_hid] = m_hpl; end
      if (free) begin
         if (j >= 0) begin
            m_hv = 1; m_hid = j; m_hpl = ppl[j]; m_hcr = 1;
            pv[j] = 0; pg[j] = 0; m_ptr = (j + 1) % N;
         end else if (bus.src_valid_i && sready) begin
            m_hv = 1; m_hid = int'(bus.src_id_i); m_hpl = int'(bus.src_payload_i); m_hcr = 0;
         end else begin
            m_hv = 0;
         end
      end
   endtask

   // compare mid-cycle against the model, then advance it with the inputs that the next edge sees
   always @(negedge clk) begin
      if (reset) mdl_reset();
      chk("out_valid", bus.out_valid_o, m_hv);
      if (m_hv) begin
         chk("out_id", bus.out_id_o, m_hid);
         chk("out_payload", bus.out_payload_o, m_hpl);
         chk("out_credit", bus.out_credit_o, m_hcr);
      end
      chk("parked_cnt", bus.parked_cnt_o, parked());
      chk("spurious", bus.spurious_credit_o, m_sp);
      chk("src_ready", bus.src_ready_o, mdl_src_ready());
      if (bus.out_valid_o && bus.out_ready_i)
         dut_log.push_back(enc(int'(bus.out_id_o), int'(bus.out_payload_o), int'(bus.out_credit_o)));
      if (!reset) mdl_step();
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int id, input int pl);
      bus.src_valid_i = 1'b1; bus.src_id_i = 3'(id); bus.src_payload_i = 5'(pl);
      tick();
      bus.src_valid_i = 1'b0;
   endtask

   task automatic park(input int id, input int pl);
      send(id, pl);
      bus.out_retry_i = 1'b1;
      tick();
      bus.out_retry_i = 1'b0;
   endtask

   task automatic grant(input int id);
      bus.credit_gnt_i = 1'b1; bus.credit_id_i = 3'(id);
      tick();
      bus.credit_gnt_i = 1'b0;
   endtask

   task automatic chk_log(input string nm, input int k, input int e);
      chk(nm, (k < dut_log.size()) ? dut_log[k] : -1, e);
   endtask

   initial begin
      reset = 1'b1;
      bus.src_valid_i = 0; bus.src_id_i = 0; bus.src_payload_i = 0;
      bus.out_ready_i = 0; bus.out_retry_i = 0; bus.credit_gnt_i = 0; bus.credit_id_i = 0;
      tick(2);
      reset = 1'b0;
      tick();

      // pass-through, back to back
      dut_log.delete();
      bus.out_ready_i = 1'b1;
      bus.src_valid_i = 1'b1; bus.src_id_i = 3'd2; bus.src_payload_i = 5'h15;
      tick();
      chk("pt_first_id", bus.out_id_o, 2);
      for (int i = 0; i < 8; i++) begin
         bus.src_id_i = 3'(i); bus.src_payload_i = 5'(i + 8);
         #1 chk("pt_ready", bus.src_ready_o, 1);
         tick();
      end
      bus.src_valid_i = 1'b0;
      tick(2);
      chk("pt_count", dut_log.size(), 9);
      chk_log("pt_log0", 0, enc(2, 'h15, 0));
      chk_log("pt_log8", 8, enc(7, 15, 0));

      // retry and credited resend
      dut_log.delete();
      bus.out_ready_i = 1'b0;
      park(5, 'h0A);
      chk("rt_cnt", bus.parked_cnt_o, 1);
      chk("rt_valid", bus.out_valid_o, 0);
      bus.src_valid_i = 1'b1; bus.src_id_i = 3'd5; bus.src_payload_i = 5'h1F;
      #1 chk("rt_block5", bus.src_ready_o, 0);
      tick();
      bus.src_id_i = 3'd3; bus.src_payload_i = 5'h03;
      #1 chk("rt_allow3", bus.src_ready_o, 1);
      tick();
      bus.src_valid_i = 1'b0; bus.out_ready_i = 1'b1;
      tick();
      grant(5);
      tick(2);
      chk("rt_cnt0", bus.parked_cnt_o, 0);
      chk_log("rt_log0", 0, enc(3, 3, 0));
      chk_log("rt_log1", 1, enc(5, 'h0A, 1));

      // parked resend beats a simultaneous source
      dut_log.delete();
      bus.out_ready_i = 1'b0;
      park(1, 'h11);
      send(7, 7);
      grant(1);
      bus.src_valid_i = 1'b1; bus.src_id_i = 3'd4; bus.src_payload_i = 5'h14; bus.out_ready_i = 1'b1;
      #1 chk("pr_src_blocked", bus.src_ready_o, 0);
      tick(2);
      bus.src_valid_i = 1'b0;
      tick(2);
      chk_log("pr_log0", 0, enc(7, 7, 0));
      chk_log("pr_log1", 1, enc(1, 'h11, 1));
      chk_log("pr_log2", 2, enc(4, 'h14, 0));

      // round-robin from a fresh pointer
      reset = 1'b1; tick(); reset = 1'b0; tick();
      dut_log.delete();
      bus.out_ready_i = 1'b0;
      park(0, 'h10); park(3, 'h13); park(6, 'h16);
      send(2, 2);
      grant(6); grant(3); grant(0);
      bus.out_ready_i = 1'b1;
      tick(4);
      chk_log("rr_log1", 1, enc(0, 'h10, 1));
      chk_log("rr_log2", 2, enc(3, 'h13, 1));
      chk_log("rr_log3", 3, enc(6, 'h16, 1));
      dut_log.delete();
      bus.out_ready_i = 1'b0;
      park(0, 0); park(6, 6);
      send(2, 2);
      grant(0); grant(6);
      bus.out_ready_i = 1'b1;
      tick(4);
      chk_log("rr2_log1", 1, enc(0, 0, 1));
      chk_log("rr2_log2", 2, enc(6, 6, 1));

      // edge events
      grant(7);
      chk("sp_pulse", bus.spurious_credit_o, 1);
      chk("sp_cnt", bus.parked_cnt_o, 0);
      dut_log.delete();
      bus.out_ready_i = 1'b1; bus.out_retry_i = 1'b1;
      send(1, 1);
      tick();
      bus.out_retry_i = 1'b0;
      chk("ar_cnt", bus.parked_cnt_o, 0);
      chk_log("ar_log0", 0, enc(1, 1, 0));
      bus.out_ready_i = 1'b0;
      park(3, 'h13);
      grant(3);
      tick();
      chk("cr_credit", bus.out_credit_o, 1);
      bus.out_retry_i = 1'b1; tick(); bus.out_retry_i = 1'b0;
      chk("cr_cnt", bus.parked_cnt_o, 1);
      chk("cr_valid", bus.out_valid_o, 0);
      grant(3);
      chk("cr_regrant_ok", bus.spurious_credit_o, 0);
      grant(3);
      chk("cr_double_gnt", bus.spurious_credit_o, 1);
      chk("cr_resend", bus.out_credit_o, 1);
      dut_log.delete();
      bus.out_ready_i = 1'b1;
      tick(2);
      chk_log("cr_log0", 0, enc(3, 'h13, 1));

      // reset while busy
      bus.out_ready_i = 1'b0;
      park(1, 1); park(2, 2); park(4, 4);
      send(5, 5);
      chk("rs_cnt3", bus.parked_cnt_o, 3);
      chk("rs_held", bus.out_valid_o, 1);
      reset = 1'b1;
      #1;
      chk("rs_valid0", bus.out_valid_o, 0);
      chk("rs_cnt0", bus.parked_cnt_o, 0);
      chk("rs_id0", bus.out_id_o, 0);
      tick();
      reset = 1'b0; bus.src_id_i = 3'd2;
      #1 chk("rs_ready", bus.src_ready_o, 1);
      grant(2);
      chk("rs_spurious", bus.spurious_credit_o, 1);
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
